ahb_counter_bank: RTL



---
 rtl/ahb_counter_bank_if.sv | 23 ++
 rtl/ahb_counter_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_counter_bank_if.sv
// AHB-Lite slave bus bundle for ahb_counter_bank.
// Only the signals this peripheral needs; HREADYOUT is driven by the slave.
interface ahb_counter_bank_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HADDR, HWDATA, HREADY, HWRITE, HTRANS, HSIZE,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HREADY, HWRITE, HTRANS, HSIZE,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_counter_bank.sv
// NCH-channel up/down timer bank on AHB-Lite: reload, compare GPIO, one-shot, IRQ.
// Optional shared tick prescaler at 0x88 enabled by defining AHB_CNT_PRESCALER_EN.
module ahb_counter_bank #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_counter_bank_if.slave bus,
  output logic [15:0]       gpio_out,
  output logic [15:0]       gpio_oeb,
  output logic [NCH-1:0]    irq
);

  logic [7:0] addr_reg;
  logic       write_reg;
  logic       word_reg;
  logic       dphase_reg;
  logic       addr_phase;

  assign addr_phase    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign bus.HREADYOUT = 1'b1;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase_reg <= 1'b0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      word_reg   <= 1'b0;
    end else begin
      dphase_reg <= addr_phase;
      if (addr_phase) begin
        addr_reg  <= bus.HADDR[7:0];
        write_reg <= bus.HWRITE;
        word_reg  <= (bus.HSIZE == 3'b010);
      end
    end
  end

  logic wr_en;
  logic rd_en;
  logic wr_flags;
  assign wr_en    = dphase_reg & write_reg & word_reg;
  assign rd_en    = dphase_reg & ~write_reg;
  assign wr_flags = wr_en & (addr_reg[7:2] == 6'h20);

  logic        tick;
  logic [31:0] presc_rdata;
`ifdef AHB_CNT_PRESCALER_EN
  logic [7:0] presc_reg;
  logic [7:0] div_reg;
  logic       wr_presc;
  assign wr_presc    = wr_en & (addr_reg[7:2] == 6'h22);
  assign tick        = (div_reg == presc_reg);
  assign presc_rdata = 32'(presc_reg);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc_reg <= '0;
      div_reg   <= '0;
    end else begin
      if (wr_presc) presc_reg <= bus.HWDATA[7:0];
      div_reg <= (wr_presc | tick) ? 8'd0 : div_reg + 8'd1;
    end
  end
`else
  assign tick        = 1'b1;
  assign presc_rdata = '0;
`endif

  logic [NCH-1:0] flag_vec;
  logic [NCH-1:0] out_vec;
  logic [NCH-1:0] oe_vec;
  logic [31:0]    ch_rdata [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
    logic [4:0]    ctrl_reg, ctrl_next;
    logic [CW-1:0] top_reg, cmp_reg, count_reg, count_next;
    logic          flag_reg, flag_next, term;
    logic          hit, wr_ctrl, wr_top, wr_cmp, wr_count;
    logic [31:0]   rdata;

    assign hit      = wr_en & (addr_reg[7:4] == 4'(gi));
    assign wr_ctrl  = hit & (addr_reg[3:2] == 2'd0);
    assign wr_top   = hit & (addr_reg[3:2] == 2'd1);
    assign wr_cmp   = hit & (addr_reg[3:2] == 2'd2);
    assign wr_count = hit & (addr_reg[3:2] == 2'd3);

    // A bus write to COUNT or CTRL replaces that cycle's tick entirely.
    always_comb begin
      ctrl_next  = ctrl_reg;
      count_next = count_reg;
      term       = 1'b0;
      if (wr_count) begin
        count_next = bus.HWDATA[CW-1:0];
      end else if (wr_ctrl) begin
        ctrl_next = bus.HWDATA[4:0];
      end else if (tick & ctrl_reg[0]) begin
        if (!ctrl_reg[1]) begin
          if (count_reg == top_reg) begin
            count_next = '0;
            term       = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else begin
          if (count_reg == '0) begin
            count_next = top_reg;
            term       = 1'b1;
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
        if (term & ctrl_reg[2]) ctrl_next[0] = 1'b0;
      end
      flag_next = term | (flag_reg & ~(wr_flags & bus.HWDATA[gi]));
    end

    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        ctrl_reg  <= '0;
        top_reg   <= '1;
        cmp_reg   <= '0;
        count_reg <= '0;
        flag_reg  <= 1'b0;
      end else begin
        ctrl_reg  <= ctrl_next;
        count_reg <= count_next;
        flag_reg  <= flag_next;
        if (wr_top) top_reg <= bus.HWDATA[CW-1:0];
        if (wr_cmp) cmp_reg <= bus.HWDATA[CW-1:0];
      end
    end

    always_comb begin
      case (addr_reg[3:2])
        2'd0:    rdata = 32'(ctrl_reg);
        2'd1:    rdata = 32'(top_reg);
        2'd2:    rdata = 32'(cmp_reg);
        default: rdata = 32'(count_reg);
      endcase
    end

    assign ch_rdata[gi] = rdata;
    assign flag_vec[gi] = flag_reg;
    assign out_vec[gi]  = ctrl_reg[4] & (count_reg < cmp_reg);
    assign oe_vec[gi]   = ctrl_reg[4];
    assign irq[gi]      = flag_reg & ctrl_reg[3];
  end

  always_comb begin
    gpio_out = '0;
    gpio_oeb = '1;
    for (int i = 0; i < NCH; i++) begin
      gpio_out[i] = out_vec[i];
      gpio_oeb[i] = ~oe_vec[i];
    end
  end

  always_comb begin
    bus.HRDATA = '0;
    if (rd_en) begin
      if (!addr_reg[7]) begin
        for (int i = 0; i < NCH; i++) begin
          if (addr_reg[6:4] == 3'(i)) bus.HRDATA = ch_rdata[i];
        end
      end else begin
        case (addr_reg[6:2])
          5'h00:   bus.HRDATA = 32'(flag_vec);
          5'h01:   bus.HRDATA = {8'(NCH), 8'(CW), 16'hC0B7};
          5'h02:   bus.HRDATA = presc_rdata;
          default: bus.HRDATA = '0;
        endcase
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.HADDR[31:8], bus.HWDATA, bus.HTRANS[0]};

endmodule
